// File: rtl/modbus_frame_timer_if.sv
// Signal bundle between the UART receiver, the RTU silence timer and the
// frame parser / transmitter. The master side drives the receiver events
// and the enable; the slave side (the timer) drives the frame qualifiers.
interface modbus_frame_timer_if;
   logic enable;
   logic rx_done;
   logic rx_state;
   logic frame_start;
   logic char_gap;
   logic frame_end;
   logic frame_bad;
   logic line_idle;

   modport master (
      output enable, rx_done, rx_state,
      input  frame_start, char_gap, frame_end, frame_bad, line_idle
   );

   modport slave (
      input  enable, rx_done, rx_state,
      output frame_start, char_gap, frame_end, frame_bad, line_idle
   );
endinterface

// File: rtl/modbus_frame_timer.sv
// Modbus RTU silence timer. Counts idle clock cycles between received
// characters and flags the 1.5-character (inside a frame) and
// 3.5-character (end of frame / line idle) limits. Above 19200 baud the
// fixed 750 us / 1750 us limits are used instead of character multiples.
module modbus_frame_timer #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int CHAR_BITS = 11,
   parameter int CNT_W     = 24
) (
   input logic                 clk_in,
   input logic                 rst_in,
   modbus_frame_timer_if.slave bus
);

   localparam longint unsigned TICKS_PER_BIT = longint'(CLK_FREQ) / longint'(BAUD_RATE);
   localparam longint unsigned TICKS_PER_MS  = longint'(CLK_FREQ) / 64'd1000;

   localparam longint unsigned T15_L = (BAUD_RATE <= 19200) ?
                                       TICKS_PER_BIT * longint'(CHAR_BITS) * 64'd15 / 64'd10 :
                                       TICKS_PER_MS * 64'd750 / 64'd1000;
   localparam longint unsigned T35_L = (BAUD_RATE <= 19200) ?
                                       TICKS_PER_BIT * longint'(CHAR_BITS) * 64'd35 / 64'd10 :
                                       TICKS_PER_MS * 64'd1750 / 64'd1000;
   localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

   // Thresholds must be ordered and representable in the silence counter.
   if (!(T15_L > 0 && T15_L < T35_L && T35_L < CNT_LIMIT)) begin : g_bad_thresholds
      $error("modbus_frame_timer: thresholds out of range (T15=%0d T35=%0d CNT_W=%0d)",
             T15_L, T35_L, CNT_W);
   end

   localparam logic [CNT_W-1:0] T15_TICKS = T15_L[CNT_W-1:0];
   localparam logic [CNT_W-1:0] T35_TICKS = T35_L[CNT_W-1:0];

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_ACTIVE = 2'd2,
      S_T15    = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic             err_reg, err_next;
   logic             frame_start_reg, frame_start_next;
   logic             char_gap_reg, char_gap_next;
   logic             frame_end_reg, frame_end_next;
   logic             frame_bad_reg, frame_bad_next;
   logic             line_idle_reg, line_idle_next;
   logic             activity;

   // State, silence counter, sticky gap error and all registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg       <= S_INIT;
         cnt_reg         <= '0;
         err_reg         <= 1'b0;
         frame_start_reg <= 1'b0;
         char_gap_reg    <= 1'b0;
         frame_end_reg   <= 1'b0;
         frame_bad_reg   <= 1'b0;
         line_idle_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         err_reg         <= err_next;
         frame_start_reg <= frame_start_next;
         char_gap_reg    <= char_gap_next;
         frame_end_reg   <= frame_end_next;
         frame_bad_reg   <= frame_bad_next;
         line_idle_reg   <= line_idle_next;
      end
   end

   // Next-state, counter and pulse generation. A threshold is taken on the
   // edge where the counter would reach it, so the pulse appears in the
   // cycle after that edge; any receiver activity on that edge wins.
   always_comb begin
      state_next       = state_reg;
      err_next         = err_reg;
      frame_start_next = 1'b0;
      char_gap_next    = 1'b0;
      frame_end_next   = 1'b0;
      frame_bad_next   = 1'b0;
      activity         = bus.rx_done | bus.rx_state;
      // Saturating increment keeps the counter from ever wrapping.
      cnt_inc          = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);
      cnt_next         = activity ? '0 : cnt_inc;

      case (state_reg)
         S_INIT: begin
            if (!activity && cnt_inc == T35_TICKS) begin
               state_next = S_IDLE;
               cnt_next   = '0;
            end
         end
         S_IDLE: begin
            cnt_next = '0;
            if (bus.rx_done) begin
               state_next       = S_ACTIVE;
               frame_start_next = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (!activity && cnt_inc == T15_TICKS) begin
               state_next    = S_T15;
               char_gap_next = 1'b1;
            end
         end
         S_T15: begin
            if (bus.rx_done) begin
               // A character after a 1.5-char gap spoils the frame.
               state_next = S_ACTIVE;
               err_next   = 1'b1;
            end else if (!bus.rx_state && cnt_inc == T35_TICKS) begin
               state_next     = S_IDLE;
               cnt_next       = '0;
               frame_end_next = 1'b1;
               frame_bad_next = err_reg;
               err_next       = 1'b0;
            end
         end
         default: begin
            state_next = S_INIT;
            cnt_next   = '0;
         end
      endcase

      // Disable forces a fresh start and silences every output.
      if (!bus.enable) begin
         state_next       = S_INIT;
         cnt_next         = '0;
         err_next         = 1'b0;
         frame_start_next = 1'b0;
         char_gap_next    = 1'b0;
         frame_end_next   = 1'b0;
         frame_bad_next   = 1'b0;
      end

      line_idle_next = (state_next == S_IDLE);
   end

   assign bus.frame_start = frame_start_reg;
   assign bus.char_gap    = char_gap_reg;
   assign bus.frame_end   = frame_end_reg;
   assign bus.frame_bad   = frame_bad_reg;
   assign bus.line_idle   = line_idle_reg;

endmodule

// File: tb/tb_modbus_frame_timer.sv
// Bench for modbus_frame_timer: two instances, one character-timed
// (1 MHz / 10000 baud: T15=1650, T35=3850) and one on the fixed limits
// (38400 baud: T15=750, T35=1750). Stimulus pushes expected events
// {frame_start, char_gap, frame_end, frame_bad, line_idle} with the clock
// edge that must produce them; monitors pop on every observed event.
module tb_modbus_frame_timer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0;
   logic rst1;
   int   cyc = 0;

   // Number of rising edges seen so far; stable at every falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   modbus_frame_timer_if if0 ();
   modbus_frame_timer_if if1 ();

   modbus_frame_timer #(
      .CLK_FREQ (1000000),
      .BAUD_RATE(10000),
      .CHAR_BITS(11),
      .CNT_W    (24)
   ) dut0 (
      .clk_in(clk),
      .rst_in(rst0),
      .bus   (if0)
   );

   modbus_frame_timer #(
      .CLK_FREQ (1000000),
      .BAUD_RATE(38400),
      .CHAR_BITS(11),
      .CNT_W    (24)
   ) dut1 (
      .clk_in(clk),
      .rst_in(rst1),
      .bus   (if1)
   );

   typedef struct {
      int         cyc;
      logic [4:0] v;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic li0_prev = 1'b0;
   logic li1_prev = 1'b0;

   function automatic void push(input int id, input int c, input logic fs, input logic cg,
                                input logic fe, input logic fb, input logic li);
      exp_t e;
      e.cyc = c;
      e.v   = {fs, cg, fe, fb, li};
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
   endfunction

   function automatic void check(input int id, input int c, input logic [4:0] got);
      exp_t e;
      n_cmp++;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
         n_bad++;
         $display("FAIL unexpected_event dut%0d: got edge %0d fs/cg/fe/fb/li=%b, required no event",
                  id, c, got);
         return;
      end
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      if (e.cyc != c || e.v !== got) begin
         n_bad++;
         $display("FAIL event dut%0d: got edge %0d fs/cg/fe/fb/li=%b, required edge %0d %b",
                  id, c, got, e.cyc, e.v);
      end else begin
         $display("ok   event dut%0d edge %0d fs/cg/fe/fb/li=%b", id, c, got);
      end
   endfunction

   function automatic void check_now(input string name, input logic [4:0] got,
                                     input logic [4:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end else begin
         $display("ok   %s = %b", name, got);
      end
   endfunction

   // Monitor for the character-timed instance.
   always @(negedge clk) begin
      if (if0.frame_start || if0.char_gap || if0.frame_end || (if0.line_idle != li0_prev))
         check(0, cyc, {if0.frame_start, if0.char_gap, if0.frame_end, if0.frame_bad, if0.line_idle});
      li0_prev = if0.line_idle;
   end

   // Monitor for the fixed-limit instance.
   always @(negedge clk) begin
      if (if1.frame_start || if1.char_gap || if1.frame_end || (if1.line_idle != li1_prev))
         check(1, cyc, {if1.frame_start, if1.char_gap, if1.frame_end, if1.frame_bad, if1.line_idle});
      li1_prev = if1.line_idle;
   end

   // Return at the falling edge just before rising edge number t.
   task automatic wait_to(input int t);
      do @(negedge clk); while (cyc + 1 < t);
   endtask

   // One-cycle rx_done sampled by rising edge number t.
   task automatic byte_at(input int id, input int t);
      wait_to(t);
      if (id == 0) if0.rx_done = 1'b1;
      else         if1.rx_done = 1'b1;
      @(negedge clk);
      if0.rx_done = 1'b0;
      if1.rx_done = 1'b0;
   endtask

   initial begin
      int c;
      int t;
      int x;

      rst0         = 1'b1;
      rst1         = 1'b1;
      if0.enable   = 1'b1;
      if0.rx_done  = 1'b0;
      if0.rx_state = 1'b0;
      if1.enable   = 1'b1;
      if1.rx_done  = 1'b0;
      if1.rx_state = 1'b0;
      repeat (3) @(negedge clk);
      check_now("reset_outputs_dut0",
                {if0.frame_start, if0.char_gap, if0.frame_end, if0.frame_bad, if0.line_idle}, 5'b0);

      // Power-up: line_idle after a full T35 of silence.
      @(negedge clk);
      c    = cyc;
      rst0 = 1'b0;
      push(0, c + 3850, 0, 0, 0, 0, 1);
      t = c + 3850 + 20;

      // Good frame: four bytes 1200 cycles apart.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      byte_at(0, t + 1200);
      byte_at(0, t + 2400);
      byte_at(0, t + 3600);
      push(0, t + 3600 + 1650, 0, 1, 0, 0, 0);
      push(0, t + 3600 + 3850, 0, 0, 1, 0, 1);
      t = t + 3600 + 3850 + 20;

      // Bad gap: 2000-cycle silence between bytes 2 and 3.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      byte_at(0, t + 100);
      push(0, t + 100 + 1650, 0, 1, 0, 0, 0);
      byte_at(0, t + 2100);
      push(0, t + 2100 + 1650, 0, 1, 0, 0, 0);
      push(0, t + 2100 + 3850, 0, 0, 1, 1, 1);
      t = t + 2100 + 3850 + 20;

      // Boundary: byte exactly on the T15 edge suppresses char_gap.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      byte_at(0, t + 1650);
      push(0, t + 1650 + 1650, 0, 1, 0, 0, 0);
      push(0, t + 1650 + 3850, 0, 0, 1, 0, 1);
      t = t + 1650 + 3850 + 20;

      // Boundary: one edge later the gap is already flagged.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      push(0, t + 1650, 0, 1, 0, 0, 0);
      byte_at(0, t + 1651);
      push(0, t + 1651 + 1650, 0, 1, 0, 0, 0);
      push(0, t + 1651 + 3850, 0, 0, 1, 1, 1);
      t = t + 1651 + 3850 + 20;

      // rx_state held for 5000 cycles after a byte freezes the counter.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      if0.rx_state = 1'b1;
      wait_to(t + 5001);
      if0.rx_state = 1'b0;
      x = t + 5000;
      push(0, x + 1650, 0, 1, 0, 0, 0);
      push(0, x + 3850, 0, 0, 1, 0, 1);
      t = x + 3850 + 20;

      // enable=0 mid-frame drops the frame; a full T35 is needed again.
      push(0, t, 1, 0, 0, 0, 0);
      byte_at(0, t);
      wait_to(t + 500);
      if0.enable = 1'b0;
      @(negedge clk);
      if0.enable = 1'b1;
      push(0, t + 500 + 3850, 0, 0, 0, 0, 1);
      wait_to(t + 500 + 3850 + 20);

      // Fixed-limit instance: power-up idle at 1750.
      @(negedge clk);
      c    = cyc;
      rst1 = 1'b0;
      push(1, c + 1750, 0, 0, 0, 0, 1);
      t = c + 1750 + 20;

      // Single-byte frame: char_gap at 750, frame_end at 1750.
      push(1, t, 1, 0, 0, 0, 0);
      byte_at(1, t);
      push(1, t + 750, 0, 1, 0, 0, 0);
      push(1, t + 1750, 0, 0, 1, 0, 1);
      t = t + 1750 + 20;

      // Reset while frame_start is high: outputs clear at once.
      push(1, t, 1, 0, 0, 0, 0);
      byte_at(1, t);
      #2;
      rst1 = 1'b1;
      #1;
      check_now("async_reset_outputs_dut1",
                {if1.frame_start, if1.char_gap, if1.frame_end, if1.frame_bad, if1.line_idle}, 5'b0);
      repeat (3) @(negedge clk);
      c    = cyc;
      rst1 = 1'b0;
      push(1, c + 1750, 0, 0, 0, 0, 1);
      wait_to(c + 1750 + 200);

      // Every expected event must have been seen by now.
      n_cmp++;
      if (q0.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events dut0: got %0d outstanding, required 0 (next edge %0d)",
                  q0.size(), q0[0].cyc);
      end
      n_cmp++;
      if (q1.size() != 0) begin
         n_bad++;
         $display("FAIL missing_events dut1: got %0d outstanding, required 0 (next edge %0d)",
                  q1.size(), q1[0].cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/modbus_frame_timer.md
# modbus_frame_timer

Parametrised Modbus RTU silence timer with both the inter-character (1.5 char) and inter-frame (3.5 char) limits. It sits between the UART receiver and the RTU frame parser. It reports frame start, frame end and frame validity, plus a line-idle qualifier for the transmitter. Thresholds derive from clock and baud parameters, and the Modbus fixed 750 us / 1750 us limits apply above 19200 baud.

## Interface
- CLK_FREQ, 50000000: system clock frequency, Hz
- BAUD_RATE, 9600: line baud rate
- CHAR_BITS, 11: bits per character (start + 8 data + parity/stop + stop)
- CNT_W, 24: silence counter width
- Derived T15_TICKS / T35_TICKS:
  - BAUD_RATE <= 19200: T15 = (CLK_FREQ/BAUD_RATE)*CHAR_BITS*15/10 and T35 = (CLK_FREQ/BAUD_RATE)*CHAR_BITS*35/10, integer division left to right.
  - BAUD_RATE > 19200: T15 = (CLK_FREQ/1000)*750/1000 and T35 = (CLK_FREQ/1000)*1750/1000.
  - Elaboration must fail unless 0 < T15 < T35 < 2^CNT_W.
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high (one clock, all flops on clk_in)
- enable  input  1  0 = synchronously hold block in S_INIT
- rx_done  input  1  one-cycle pulse: receiver finished a byte
- rx_state  input  1  receiver busy (start bit seen, byte in progress)
- frame_start  output  1  one-cycle pulse: first byte of a new frame received
- char_gap  output  1  one-cycle pulse: silence inside a frame reached T15
- frame_end  output  1  one-cycle pulse: silence after a frame reached T35
- frame_bad  output  1  valid only with frame_end; 1 = frame contained a >T15 gap
- line_idle  output  1  level: at least T35 silence observed, no frame open

## Operation
- Silence counter cnt (CNT_W bits):
  - cleared on any cycle with rx_done=1 or rx_state=1;
  - otherwise increments by 1;
  - never wraps; it is cleared on every state change into S_IDLE and stops counting there.
- States:
  - S_INIT: after reset or enable=0. line_idle=0. When cnt reaches T35 -> S_IDLE; no frame_end is issued.
  - S_IDLE: line_idle=1. rx_done -> S_ACTIVE and pulse frame_start. rx_state alone leaves line_idle=1 until rx_done arrives.
  - S_ACTIVE: frame open. rx_done keeps the state. cnt reaching T15 -> S_T15 and pulse char_gap.
  - S_T15: rx_done sets sticky err and returns to S_ACTIVE. cnt reaching T35 -> S_IDLE with frame_end=1, frame_bad=err, and err cleared.
- Simultaneous events:
  - rx_done on the same edge as a threshold hit: rx_done wins; cnt clears and no threshold pulse is issued.
  - enable=0 overrides everything: S_INIT, cnt=0, err=0, all outputs 0 on the next edge.
- Reset mid-frame: the frame is discarded with no frame_end; S_INIT must then see a full T35 of silence before line_idle.

## Timing
- Reset values: state S_INIT, cnt 0, err 0. frame_start, char_gap, frame_end, frame_bad and line_idle are all 0.
- All outputs are registered.
- Counting reference: rx_done sampled at edge E0 gives cnt=0 after E0.
  - After E0: cnt=k after edge Ek when uninterrupted.
  - Thresholds: char_gap is high in the cycle after E_T15; frame_end and frame_bad are high in the cycle after E_T35.
  - Both pulses are exactly one cycle.
- frame_start is high in the cycle after the edge sampling the first rx_done from S_IDLE.
- line_idle rises in the same cycle as frame_end.
  - It falls in the cycle after the edge sampling rx_done in S_IDLE, i.e. together with frame_start.
- rx_state high at any cycle freezes cnt at 0, so a byte in progress is never counted as silence.

## Test plan
Default bench parameters: CLK_FREQ=1000000, BAUD_RATE=10000, giving T15=1650 and T35=3850.

- Power-up idle: reset, no rx activity.
  - line_idle rises exactly 3850 cycles after reset release.
  - frame_start, char_gap and frame_end stay 0.
- Good frame: 4 rx_done pulses, 1200 cycles apart, starting in S_IDLE.
  - frame_start on the first pulse; no char_gap.
  - frame_end=1 and frame_bad=0 exactly 3850 cycles after the last rx_done.
- Bad gap: 2 bytes, then a 2000-cycle gap, then a byte.
  - char_gap fires 1650 cycles after byte 2.
  - frame_end 3850 cycles after byte 3, with frame_bad=1.
- Boundary: rx_done arrives exactly on the T15 edge.
  - No char_gap; the frame ends good.
  - A repeat with rx_done one cycle later must produce char_gap.
- rx_state hold: rx_state high for 5000 cycles after a byte, then low.
  - No frame_end during the hold.
  - frame_end 3850 cycles after rx_state falls.
- Fixed timing and reset:
  - BAUD_RATE=38400 gives T15=750 and T35=1750; check both pulse positions.
  - Assert rst_in mid-frame: all outputs 0 immediately, and the next line_idle comes 1750 cycles after release.
